// File: rtl/scan_keypad4x4.sv
// scan_keypad4x4: 4x4 matrix keypad column scanner, whole-matrix debouncer and key decoder.
// Latency: a press stable from a frame start is accepted after DEBOUNCE+1 frames (4*SCAN_DIV clk each), decoded one clk later.
// Backpressure: none; key_valid is a one-cycle strobe that the consumer must take when it fires.
module scan_keypad4x4 #(
    parameter logic [15:0] SCAN_DIV = 16'd27_000,
    parameter logic [3:0]  DEBOUNCE = 4'd4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held,
    output logic       key_multi
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 16'd1);

    logic [3:0]       row_m;
    logic [3:0]       row_s;
    logic [DIV_W-1:0] div;
    logic [1:0]       col_idx;
    logic [1:0]       col_idx_nxt;
    logic             sample;
    logic             frame_end;
    logic [15:0]      snap;
    logic [15:0]      snap_nxt;
    logic [15:0]      prev;
    logic [15:0]      deb;
    logic [15:0]      deb_q;
    logic [3:0]       stable_cnt;
    logic [3:0]       cnt_nxt;
    logic             deb_none;
    logic             deb_one;
    logic [3:0]       deb_idx;

    always_comb begin
        sample      = (div == DIV_LAST);
        frame_end   = sample && (col_idx == 2'd3);
        col_idx_nxt = col_idx + 2'd1;

        // Snapshot bit index is col*4 + row; a 1 means the key is pressed.
        snap_nxt = snap;
        snap_nxt[{col_idx, 2'b00} +: 4] = ~row_s;

        if (snap_nxt != prev) begin
            cnt_nxt = 4'd0;
        end else if (stable_cnt == DEBOUNCE) begin
            cnt_nxt = stable_cnt;
        end else begin
            cnt_nxt = stable_cnt + 4'd1;
        end

        deb_none = (deb == 16'd0);
        deb_one  = !deb_none && ((deb & (deb - 16'd1)) == 16'd0);
        deb_idx  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (deb[i]) begin
                deb_idx = 4'(i);
            end
        end
    end

    // Column drive tracks col_idx so the sample at div==DIV_LAST has settled for SCAN_DIV-2 clks.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            row_m   <= 4'hF;
            row_s   <= 4'hF;
            div     <= '0;
            col_idx <= 2'd0;
            col     <= 4'b1110;
        end else begin
            row_m <= row;
            row_s <= row_m;
            if (sample) begin
                div     <= '0;
                col_idx <= col_idx_nxt;
                col     <= ~(4'b0001 << col_idx_nxt);
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            snap       <= 16'd0;
            prev       <= 16'd0;
            stable_cnt <= 4'd0;
            deb        <= 16'd0;
        end else if (sample) begin
            snap <= snap_nxt;
            if (frame_end) begin
                prev       <= snap_nxt;
                stable_cnt <= cnt_nxt;
                if (cnt_nxt == DEBOUNCE) begin
                    deb <= snap_nxt;
                end
            end
        end
    end

    // deb changes only at frame ends, so deb != deb_q marks the single cycle after an accepted change.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            deb_q     <= 16'd0;
            key       <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            key_multi <= 1'b0;
        end else begin
            deb_q     <= deb;
            key_valid <= 1'b0;
            if (deb_one) begin
                key       <= {deb_idx[1:0], deb_idx[3:2]};
                key_held  <= 1'b1;
                key_multi <= 1'b0;
                key_valid <= (deb != deb_q);
            end else begin
                key_held  <= 1'b0;
                key_multi <= !deb_none;
            end
        end
    end
endmodule

// File: tb/tb_scan_keypad4x4.sv
// Bench for scan_keypad4x4: models the key matrix, scores key_valid pulses against an expected-key queue.
module tb_scan_keypad4x4;
    localparam logic [15:0] SCAN_DIV = 16'd4;
    localparam logic [3:0]  DEBOUNCE = 4'd3;
    localparam int FRAME = 16;
    localparam int LAT   = 4 * FRAME + 2;

    typedef struct {
        int         k;
        logic [3:0] col;
        logic [3:0] key;
        logic       held;
        logic       multi;
    } scan_vec_t;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] code;
    } key_vec_t;

    logic        clk;
    logic        nrst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;
    logic        key_multi;
    logic [15:0] pressed;
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_exp;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int k = 0;
    int pulse_cnt = 0;

    scan_keypad4x4 #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk(clk),
        .nrst(nrst),
        .row(row),
        .col(col),
        .key(key),
        .key_valid(key_valid),
        .key_held(key_held),
        .key_multi(key_multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pressed bit r*4+c shorts row r to column c
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(pressed[r*4 +: 4] & ~col);
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!nrst) k <= 0;
        else k <= k + 1;
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulse_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: key=%h, no pulse expected", key);
            end else begin
                mon_exp = exp_q.pop_front();
                if (key !== mon_exp) begin
                    bad++;
                    $display("FAIL pulse_key: got %h want %h", key, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic to_frame_start();
        do tick(); while (k % FRAME != 0);
    endtask

    task automatic wait_pulse(input string name, input int budget, output int dt);
        int p0;
        int n;
        p0 = pulse_cnt;
        n = 0;
        while (pulse_cnt == p0 && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (pulse_cnt == p0) begin
            bad++;
            $display("FAIL %s: no key_valid within %0d cycles", name, budget);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        dt = n;
    endtask

    task automatic chk_outs(input string name, input logic [3:0] c, input logic [3:0] kk,
                            input logic h, input logic m);
        chk({name, "_col"}, 32'(col), 32'(c));
        chk({name, "_key"}, 32'(key), 32'(kk));
        chk({name, "_valid"}, 32'(key_valid), 32'(1'b0));
        chk({name, "_held"}, 32'(key_held), 32'(h));
        chk({name, "_multi"}, 32'(key_multi), 32'(m));
    endtask

    scan_vec_t sv[8];
    key_vec_t  kv[5];

    initial begin
        int dt;
        int p0;

        sv[0] = '{0,  4'b1110, 4'h0, 1'b0, 1'b0};
        sv[1] = '{3,  4'b1110, 4'h0, 1'b0, 1'b0};
        sv[2] = '{4,  4'b1101, 4'h0, 1'b0, 1'b0};
        sv[3] = '{7,  4'b1101, 4'h0, 1'b0, 1'b0};
        sv[4] = '{8,  4'b1011, 4'h0, 1'b0, 1'b0};
        sv[5] = '{11, 4'b1011, 4'h0, 1'b0, 1'b0};
        sv[6] = '{12, 4'b0111, 4'h0, 1'b0, 1'b0};
        sv[7] = '{16, 4'b1110, 4'h0, 1'b0, 1'b0};

        kv[0] = '{0, 3, 4'h3};
        kv[1] = '{3, 0, 4'hC};
        kv[2] = '{1, 2, 4'h6};
        kv[3] = '{3, 3, 4'hF};
        kv[4] = '{0, 0, 4'h0};

        // reset and column walk
        nrst = 1'b0;
        pressed = 16'h0000;
        ticks(3);
        chk_outs("reset", 4'b1110, 4'h0, 1'b0, 1'b0);
        nrst = 1'b1;
        foreach (sv[i]) begin
            while (k < sv[i].k) tick();
            chk_outs($sformatf("scan_k%0d", sv[i].k), sv[i].col, sv[i].key, sv[i].held, sv[i].multi);
        end

        // single press r2,c1 held
        to_frame_start();
        exp_q.push_back(4'h9);
        pressed[2*4+1] = 1'b1;
        wait_pulse("press_pulse", LAT, dt);
        chk("press_lat_ok", 32'(dt >= 4*FRAME && dt <= LAT), 32'd1);
        chk("press_key", 32'(key), 32'h9);
        chk("press_held", 32'(key_held), 32'd1);
        tick();
        chk("press_pulse_width", 32'(key_valid), 32'd0);
        p0 = pulse_cnt;
        ticks(20 * FRAME);
        chk("press_no_repeat", 32'(pulse_cnt), 32'(p0));
        chk("press_still_held", 32'(key_held), 32'd1);
        pressed = 16'h0000;
        ticks(6 * FRAME);
        chk("release_held", 32'(key_held), 32'd0);
        chk("release_key", 32'(key), 32'h9);
        chk("release_multi", 32'(key_multi), 32'd0);

        // bounce of 2 and 3 frames on r0,c3 is rejected
        for (int len = 2; len <= 3; len++) begin
            to_frame_start();
            p0 = pulse_cnt;
            pressed[0*4+3] = 1'b1;
            ticks(len * FRAME);
            pressed = 16'h0000;
            ticks(6 * FRAME);
            chk($sformatf("bounce%0d_pulses", len), 32'(pulse_cnt), 32'(p0));
            chk($sformatf("bounce%0d_key", len), 32'(key), 32'h9);
            chk($sformatf("bounce%0d_held", len), 32'(key_held), 32'd0);
        end

        // key code formatting across the matrix
        foreach (kv[i]) begin
            to_frame_start();
            exp_q.push_back(kv[i].code);
            pressed[kv[i].r*4 + kv[i].c] = 1'b1;
            wait_pulse($sformatf("code_r%0dc%0d_pulse", kv[i].r, kv[i].c), LAT, dt);
            chk($sformatf("code_r%0dc%0d_key", kv[i].r, kv[i].c), 32'(key), 32'(kv[i].code));
            chk($sformatf("code_r%0dc%0d_held", kv[i].r, kv[i].c), 32'(key_held), 32'd1);
            pressed = 16'h0000;
            ticks(6 * FRAME);
            chk($sformatf("code_r%0dc%0d_rel", kv[i].r, kv[i].c), 32'(key_held), 32'd0);
        end

        // two keys together, then one released
        to_frame_start();
        pressed[1*4+0] = 1'b1;
        pressed[3*4+2] = 1'b1;
        ticks(4 * FRAME);
        chk("multi_early", 32'(key_multi), 32'd0);
        ticks(2);
        chk("multi_set", 32'(key_multi), 32'd1);
        chk("multi_held", 32'(key_held), 32'd0);
        chk("multi_key", 32'(key), 32'(kv[4].code));
        to_frame_start();
        exp_q.push_back(4'hE);
        pressed[1*4+0] = 1'b0;
        wait_pulse("multi_to_b_pulse", LAT, dt);
        chk("multi_to_b_key", 32'(key), 32'hE);
        chk("multi_to_b_multi", 32'(key_multi), 32'd0);
        chk("multi_to_b_held", 32'(key_held), 32'd1);
        pressed = 16'h0000;
        ticks(6 * FRAME);

        // press, release, press again
        for (int rep = 0; rep < 2; rep++) begin
            to_frame_start();
            exp_q.push_back(4'h9);
            pressed[2*4+1] = 1'b1;
            wait_pulse($sformatf("repress%0d_pulse", rep), LAT, dt);
            chk($sformatf("repress%0d_key", rep), 32'(key), 32'h9);
            pressed = 16'h0000;
            ticks(6 * FRAME);
            chk($sformatf("repress%0d_gap_held", rep), 32'(key_held), 32'd0);
        end

        // reset during frame 2 of a press restarts debounce from scratch
        to_frame_start();
        pressed[2*4+1] = 1'b1;
        ticks(FRAME + 5);
        nrst = 1'b0;
        tick();
        chk_outs("midreset", 4'b1110, 4'h0, 1'b0, 1'b0);
        nrst = 1'b1;
        exp_q.push_back(4'h9);
        wait_pulse("midreset_pulse", LAT, dt);
        chk("midreset_lat_ok", 32'(dt >= 4*FRAME && dt <= LAT), 32'd1);
        chk("midreset_key", 32'(key), 32'h9);
        pressed = 16'h0000;
        ticks(2 * FRAME);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
